// File: rtl/pcr_valve_sequencer.sv
// Pneumatic valve and thermal-phase sequencer for the PCR chip: LOAD, SETTLE, n x (DENAT, ANNEAL), DISPENSE, DONE.
// Define PCR_SEQ_SENSE_EN to supervise the valve pressure switches and trap timeouts in FAULT.
module pcr_valve_sequencer #(
    parameter int unsigned CYC_W        = 6,
    parameter int unsigned TICK_W       = 16,
    parameter int unsigned LOAD_TICKS   = 100,
    parameter int unsigned SETTLE_TICKS = 20,
    parameter int unsigned DEN_TICKS    = 300,
    parameter int unsigned ANN_TICKS    = 600,
    parameter int unsigned DISP_TICKS   = 100,
    parameter int unsigned SENSE_TO     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CYC_W-1:0] n_cycles,
    input  logic             sense0,
    input  logic             sense1,
    output logic             valve0_en,
    output logic             valve1_en,
    output logic             heat_hi,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [CYC_W-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_DENAT, S_ANNEAL, S_DISPENSE, S_DONE, S_FAULT
    } state_e;

    state_e            state_q, state_d;
    logic [TICK_W-1:0] timer_q, timer_d;
    logic [CYC_W-1:0]  ncyc_q, ncyc_d;
    logic [CYC_W-1:0]  cnt_q, cnt_d;
    logic              valve0_q, valve0_d;
    logic              valve1_q, valve1_d;
    logic              heat_q, heat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic              expired;

`ifdef PCR_SEQ_SENSE_EN
    logic seen_q, seen_d;
    logic sense_win, sense_lvl;
`else
    logic unused_sense;
    assign unused_sense = ^{sense0, sense1, 1'(SENSE_TO)};
`endif

    // Timer reload value on entry; a state lasts exactly its TICKS count.
    function automatic logic [TICK_W-1:0] dwell(input state_e s);
        case (s)
            S_LOAD:     return TICK_W'(LOAD_TICKS - 1);
            S_SETTLE:   return TICK_W'(SETTLE_TICKS - 1);
            S_DENAT:    return TICK_W'(DEN_TICKS - 1);
            S_ANNEAL:   return TICK_W'(ANN_TICKS - 1);
            S_DISPENSE: return TICK_W'(DISP_TICKS - 1);
            default:    return '0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        ncyc_d  = ncyc_q;
        cnt_d   = cnt_q;
        expired = (timer_q == '0);
        timer_d = expired ? timer_q : timer_q - TICK_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    ncyc_d  = n_cycles;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD:     if (expired) state_d = S_SETTLE;
            S_SETTLE:   if (expired) state_d = (ncyc_q != '0) ? S_DENAT : S_DISPENSE;
            S_DENAT:    if (expired) state_d = S_ANNEAL;
            S_ANNEAL: begin
                if (expired) begin
                    cnt_d   = cnt_q + CYC_W'(1);
                    state_d = (cnt_d < ncyc_q) ? S_DENAT : S_DISPENSE;
                end
            end
            S_DISPENSE: if (expired) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_IDLE;
        endcase

`ifdef PCR_SEQ_SENSE_EN
        // Sensor must be seen by the SENSE_TO-th cycle of LOAD/DISPENSE; later drops are ignored.
        sense_win = (state_q == S_LOAD) || (state_q == S_DISPENSE);
        sense_lvl = (state_q == S_LOAD) ? sense0 : sense1;
        seen_d    = sense_win && (seen_q || sense_lvl);
        if (sense_win && !seen_d && ((dwell(state_q) - timer_q) == TICK_W'(SENSE_TO - 1)))
            state_d = S_FAULT;
`endif

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = cnt_q;
        end

        if (state_d != state_q) begin
            timer_d = dwell(state_d);
`ifdef PCR_SEQ_SENSE_EN
            seen_d  = 1'b0;
`endif
        end

        valve0_d = (state_d == S_LOAD);
        valve1_d = (state_d == S_DISPENSE);
        heat_d   = (state_d == S_DENAT);
        busy_d   = (state_d == S_LOAD) || (state_d == S_SETTLE) || (state_d == S_DENAT) ||
                   (state_d == S_ANNEAL) || (state_d == S_DISPENSE);
        done_d   = (state_d == S_DONE);
        fault_d  = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            ncyc_q   <= '0;
            cnt_q    <= '0;
            valve0_q <= 1'b0;
            valve1_q <= 1'b0;
            heat_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
`ifdef PCR_SEQ_SENSE_EN
            seen_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            ncyc_q   <= ncyc_d;
            cnt_q    <= cnt_d;
            valve0_q <= valve0_d;
            valve1_q <= valve1_d;
            heat_q   <= heat_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
`ifdef PCR_SEQ_SENSE_EN
            seen_q   <= seen_d;
`endif
        end
    end

    assign valve0_en = valve0_q;
    assign valve1_en = valve1_q;
    assign heat_hi   = heat_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pcr_valve_sequencer.sv
// Self-checking bench for pcr_valve_sequencer: randomized runs checked cycle by cycle against a phase-schedule model.
`timescale 1ns/1ps
module tb_pcr_valve_sequencer;

    localparam int unsigned CYC_W    = 6;
    localparam int unsigned LOAD_T   = 4;
    localparam int unsigned SETTLE_T = 2;
    localparam int unsigned DEN_T    = 3;
    localparam int unsigned ANN_T    = 5;
    localparam int unsigned DISP_T   = 4;
    localparam int unsigned SENSE_T  = 2;

    logic             clk = 1'b0;
    logic             rst, start, abort, sense0, sense1;
    logic [CYC_W-1:0] n_cycles;
    logic             valve0_en, valve1_en, heat_hi, busy, done, fault;
    logic [CYC_W-1:0] cycle_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] q[$];

    always #5 clk = ~clk;

    pcr_valve_sequencer #(
        .CYC_W(CYC_W), .TICK_W(16), .LOAD_TICKS(LOAD_T), .SETTLE_TICKS(SETTLE_T),
        .DEN_TICKS(DEN_T), .ANN_TICKS(ANN_T), .DISP_TICKS(DISP_T), .SENSE_TO(SENSE_T)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .n_cycles(n_cycles),
        .sense0(sense0), .sense1(sense1), .valve0_en(valve0_en), .valve1_en(valve1_en),
        .heat_hi(heat_hi), .busy(busy), .done(done), .fault(fault), .cycle_cnt(cycle_cnt)
    );

    // Record layout: {fault, valve0, valve1, heat, busy, done, cnt[5:0]}
    function automatic logic [11:0] rec(input logic f, v0, v1, ht, bz, dn, input logic [5:0] cn);
        return {f, v0, v1, ht, bz, dn, cn};
    endfunction

    function automatic logic [11:0] obs();
        return {fault, valve0_en, valve1_en, heat_hi, busy, done, cycle_cnt};
    endfunction

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got f/v0/v1/ht/bz/dn=%b cnt=%0d, expected %b cnt=%0d",
                     tag, got[11:6], got[5:0], exp[11:6], exp[5:0]);
        end
    endtask

    // Expected per-cycle outputs from start acceptance through the DONE pulse.
    task automatic build(input int n);
        q.delete();
        for (int i = 0; i < LOAD_T; i++)   q.push_back(rec(0, 1, 0, 0, 1, 0, 6'd0));
        for (int i = 0; i < SETTLE_T; i++) q.push_back(rec(0, 0, 0, 0, 1, 0, 6'd0));
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < DEN_T; i++) q.push_back(rec(0, 0, 0, 1, 1, 0, 6'(c)));
            for (int i = 0; i < ANN_T; i++) q.push_back(rec(0, 0, 0, 0, 1, 0, 6'(c)));
        end
        for (int i = 0; i < DISP_T; i++)   q.push_back(rec(0, 0, 1, 0, 1, 0, 6'(n)));
        q.push_back(rec(0, 0, 0, 0, 0, 1, 6'(n)));
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge in the first idle cycle afterwards.
    task automatic run(input int n, input int abort_at, input bit noise);
        logic [11:0] e;
        build(n);
        start    = 1'b1;
        n_cycles = 6'(n);
        @(posedge clk);
        for (int c = 1; c <= q.size(); c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            e = q[c-1];
            chk($sformatf("run n=%0d cyc %0d", n, c), obs(), e);
            if (c == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk($sformatf("abort n=%0d at %0d", n, c), obs(), rec(0, 0, 0, 0, 0, 0, e[5:0]));
                return;
            end
            if (noise) begin
                start    = e[7] && ($urandom_range(0, 3) == 0);
                n_cycles = 6'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("idle after n=%0d", n), obs(), rec(0, 0, 0, 0, 0, 0, 6'(n)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; n_cycles = '0; sense0 = 1'b1; sense1 = 1'b1;
        #1;
        chk("reset state", obs(), 12'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle after reset", obs(), 12'd0);

        run(2, 0, 1'b0);
        run(0, 0, 1'b0);
        run(2, 12, 1'b0);
        run(1, 0, 1'b0);

        // start together with abort in IDLE is ignored
        start = 1'b1; abort = 1'b1; n_cycles = 6'd3;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start+abort idle", obs(), rec(0, 0, 0, 0, 0, 0, 6'd1));
        @(negedge clk);
        chk("start+abort idle hold", obs(), rec(0, 0, 0, 0, 0, 0, 6'd1));

        // asynchronous reset in the middle of DENAT
        start = 1'b1; n_cycles = 6'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("denat before reset", obs(), rec(0, 0, 0, 1, 1, 0, 6'd0));
        #2 rst = 1'b1;
        #1 chk("async reset", obs(), 12'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle after mid reset", obs(), 12'd0);
        run(1, 0, 1'b0);

`ifdef PCR_SEQ_SENSE_EN
        // sense0 never asserts: FAULT after SENSE_T LOAD cycles
        sense0 = 1'b0; start = 1'b1; n_cycles = 6'd1;
        @(posedge clk);
        for (int c = 1; c <= SENSE_T; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("sense load cyc %0d", c), obs(), rec(0, 1, 0, 0, 1, 0, 6'd0));
        end
        @(negedge clk);
        chk("sense fault", obs(), rec(1, 0, 0, 0, 0, 0, 6'd0));
        @(negedge clk);
        chk("sense fault sticky", obs(), rec(1, 0, 0, 0, 0, 0, 6'd0));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("fault abort", obs(), rec(0, 0, 0, 0, 0, 0, 6'd0));
        sense0 = 1'b1;
        run(1, 0, 1'b0);
`endif

        for (int r = 0; r < 24; r++) begin
            int n, ab;
            n  = $urandom_range(0, 3);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 36) : 0;
            run(n, ab, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
